// File: rtl/apb_reg_pkg.sv
// Shared types and widths for the APB register bank and its slave FSM.
package apb_reg_pkg;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/apb_slave_fsm.sv
// APB access-phase sequencer: wait-state down-counter, registered pready,
// read-load and write-commit strobes.
//   state | meaning
//   IDLE  | no transfer in progress, waiting for psel & penable
//   WAIT  | counting programmed wait states; psel drop aborts
//   DONE  | pready high for one cycle, write commits at its closing edge
module apb_slave_fsm
  import apb_reg_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic pclk,
  input  logic presetn,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic load,
  output logic commit
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state  <= IDLE;
      cnt    <= '0;
      pready <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      pready <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (psel && penable) begin
          if (WAIT_STATES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_nxt = DONE;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign load   = (state != DONE) && (state_nxt == DONE);
  assign commit = (state == DONE);

endmodule

// File: rtl/apb_reg_bank.sv
// Parametrised APB4 register bank with byte-strobe writes, hardware-fed
// read-only registers, programmable wait states and pslverr on bad accesses.
module apb_reg_bank
  import apb_reg_pkg::*;
#(
  parameter int                    ADDR_W      = 16,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_W-1:0]     RESET_VAL   = 32'h0
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic [2:0]                 pprot,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [DATA_W-1:0]          pwdata,
  input  logic [STRB_W-1:0]          pwstrb,
  output logic                       pready,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pslverr,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  input  logic [NUM_REGS*DATA_W-1:0] hw_rdata
);

  logic [ADDR_W-3:0]  idx;
  logic               in_range;
  logic               ro_hit;
  logic               err;
  logic [DATA_W-1:0]  rd_val;
  logic               load;
  logic               commit;
  logic               unused_bits;

  // Protection and byte offset carry no meaning for this bank.
  assign unused_bits = ^{pprot, paddr[1:0]};

  assign idx      = paddr[ADDR_W-1:2];
  assign in_range = (int'(idx) < NUM_REGS);

  apb_slave_fsm #(
    .WAIT_STATES (WAIT_STATES)
  ) u_fsm (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pready  (pready),
    .load    (load),
    .commit  (commit)
  );

  always_comb begin
    rd_val = '0;
    ro_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(idx) == i) begin
        ro_hit = RO_MASK[i];
        rd_val = RO_MASK[i] ? hw_rdata[DATA_W*i +: DATA_W] : reg_q[DATA_W*i +: DATA_W];
      end
    end
  end

  assign err = !in_range || (pwrite && ro_hit);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (RO_MASK[g]) begin : g_ro
      // RO entries hold no state; their value lives in hw_rdata.
      assign reg_q[DATA_W*g +: DATA_W] = RESET_VAL;
    end else begin : g_rw
      logic [DATA_W-1:0] q;
      always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
          q <= RESET_VAL;
        end else if (commit && pwrite && !err && (int'(idx) == g)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (pwstrb[b]) q[8*b +: 8] <= pwdata[8*b +: 8];
          end
        end
      end
      assign reg_q[DATA_W*g +: DATA_W] = q;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prdata  <= '0;
      pslverr <= 1'b0;
    end else if (load) begin
      prdata  <= (err || pwrite) ? '0 : rd_val;
      pslverr <= err;
    end else if (pready) begin
      prdata  <= '0;
      pslverr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Bench for apb_reg_bank: one zero-wait bank with an RO register and one
// three-wait-state bank, checked against a bench-side register model.
module tb_apb_reg_bank;
  localparam int          ADDR_W = 16;
  localparam int          NR     = 8;
  localparam logic [31:0] RV_A   = 32'h1111_2222;
  localparam logic [31:0] RV_B   = 32'h5A5A_0F0F;
  localparam logic [31:0] HW2    = 32'h1234_5678;

  logic              pclk = 1'b0;
  logic              presetn = 1'b0;
  logic [ADDR_W-1:0] paddr = '0;
  logic [2:0]        pprot = '0;
  logic              psel_a = 1'b0, psel_b = 1'b0;
  logic              penable = 1'b0, pwrite = 1'b0;
  logic [31:0]       pwdata = '0;
  logic [3:0]        pwstrb = '0;
  logic              pready_a, pready_b, pslverr_a, pslverr_b;
  logic [31:0]       prdata_a, prdata_b;
  logic [NR*32-1:0]  reg_q_a, reg_q_b;
  logic [NR*32-1:0]  hw_a, hw_b;

  always #5 pclk = ~pclk;

  apb_reg_bank #(
    .ADDR_W(ADDR_W), .NUM_REGS(NR), .WAIT_STATES(0),
    .RO_MASK(8'h04), .RESET_VAL(RV_A)
  ) dut_a (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pprot(pprot),
    .psel(psel_a), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pwstrb(pwstrb), .pready(pready_a), .prdata(prdata_a), .pslverr(pslverr_a),
    .reg_q(reg_q_a), .hw_rdata(hw_a)
  );

  apb_reg_bank #(
    .ADDR_W(ADDR_W), .NUM_REGS(NR), .WAIT_STATES(3),
    .RO_MASK(8'h00), .RESET_VAL(RV_B)
  ) dut_b (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pprot(pprot),
    .psel(psel_b), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pwstrb(pwstrb), .pready(pready_b), .prdata(prdata_b), .pslverr(pslverr_b),
    .reg_q(reg_q_b), .hw_rdata(hw_b)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [2][NR];
  exp_t        sb [$];

  function automatic logic cur_pready(input int sel);
    return sel != 0 ? pready_b : pready_a;
  endfunction
  function automatic logic [31:0] cur_prdata(input int sel);
    return sel != 0 ? prdata_b : prdata_a;
  endfunction
  function automatic logic cur_pslverr(input int sel);
    return sel != 0 ? pslverr_b : pslverr_a;
  endfunction
  function automatic logic [31:0] cur_reg(input int sel, input int i);
    return sel != 0 ? reg_q_b[32*i +: 32] : reg_q_a[32*i +: 32];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      model[0][i] = RV_A;
      model[1][i] = RV_B;
    end
  endtask

  task automatic check_regq(input int sel);
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (cur_reg(sel, i) !== model[sel][i]) begin
        errors++;
        $display("FAIL reg_q dut%0d[%0d]: got %h expected %h", sel, i, cur_reg(sel, i), model[sel][i]);
      end
    end
  endtask

  // One complete APB transfer, starting #1 after a rising edge.
  task automatic xfer(input int sel, input bit wr, input logic [ADDR_W-1:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
    int          idx;
    int          ws;
    int          cyc;
    bit          err;
    bit          done;
    logic [31:0] exp_rd;
    exp_t        e;
    exp_t        got;
    idx    = int'(addr[ADDR_W-1:2]);
    ws     = (sel != 0) ? 3 : 0;
    err    = (idx >= NR) || (wr && sel == 0 && idx == 2);
    exp_rd = '0;
    if (!wr && !err) exp_rd = (sel == 0 && idx == 2) ? HW2 : model[sel][idx];
    e.rdata = exp_rd;
    e.err   = err;
    sb.push_back(e);

    paddr = addr; pwrite = wr; pwdata = data; pwstrb = strb; penable = 1'b0;
    if (sel != 0) psel_b = 1'b1; else psel_a = 1'b1;
    @(negedge pclk);
    checks++;
    if (cur_pready(sel) !== 1'b0 || cur_prdata(sel) !== 32'h0 || cur_pslverr(sel) !== 1'b0) begin
      errors++;
      $display("FAIL idle_out dut%0d: got pready=%b prdata=%h pslverr=%b expected 0/0/0",
               sel, cur_pready(sel), cur_prdata(sel), cur_pslverr(sel));
    end
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge pclk);
      cyc++;
      if (cur_pready(sel) === 1'b1) begin
        done = 1'b1;
        got.rdata = cur_prdata(sel);
        got.err   = cur_pslverr(sel);
        e = sb.pop_front();
        checks++;
        if (cyc != ws + 2) begin
          errors++;
          $display("FAIL latency dut%0d addr=%h: got %0d cycles expected %0d", sel, addr, cyc, ws + 2);
        end
        checks++;
        if (got.rdata !== e.rdata) begin
          errors++;
          $display("FAIL prdata dut%0d addr=%h: got %h expected %h", sel, addr, got.rdata, e.rdata);
        end
        checks++;
        if (got.err !== e.err) begin
          errors++;
          $display("FAIL pslverr dut%0d addr=%h: got %b expected %b", sel, addr, got.err, e.err);
        end
      end
    end
    if (!done) begin
      void'(sb.pop_front());
      checks++;
      errors++;
      $display("FAIL timeout dut%0d addr=%h: got no pready expected one within 40 cycles", sel, addr);
    end
    @(posedge pclk); #1;
    if (done && wr && !err) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[sel][idx][8*b +: 8] = data[8*b +: 8];
    end
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    checks++;
    if ({pready_a, pslverr_a, pready_b, pslverr_b} !== 4'b0 || prdata_a !== 32'h0 || prdata_b !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: got rdy/err a=%b%b b=%b%b prdata a=%h b=%h expected all 0",
               pready_a, pslverr_a, pready_b, pslverr_b, prdata_a, prdata_b);
    end
    check_regq(0);
    check_regq(1);
    @(negedge pclk);
    presetn = 1'b1;
    @(posedge pclk); #1;
  endtask

  task automatic test_read_all();
    for (int i = 0; i < NR; i++) xfer(0, 1'b0, ADDR_W'(4 * i), 32'h0, 4'h0);
  endtask

  task automatic test_strobes();
    xfer(0, 1'b1, 16'h000C, 32'h0000_0000, 4'hF);
    xfer(0, 1'b1, 16'h000C, 32'hDEAD_BEEF, 4'b0101);
    xfer(0, 1'b0, 16'h000C, 32'h0, 4'h0);
    check_regq(0);
    checks++;
    if (reg_q_a[127:96] !== 32'h00AD_00EF) begin
      errors++;
      $display("FAIL strobe_merge: got %h expected 00ad00ef", reg_q_a[127:96]);
    end
    xfer(0, 1'b1, 16'h000C, 32'hFFFF_FFFF, 4'h0);
    check_regq(0);
    xfer(0, 1'b0, 16'h000F, 32'h0, 4'h0);
  endtask

  task automatic test_read_only();
    xfer(0, 1'b0, 16'h0008, 32'h0, 4'h0);
    xfer(0, 1'b1, 16'h0008, 32'hFFFF_FFFF, 4'hF);
    check_regq(0);
    xfer(0, 1'b0, 16'h0008, 32'h0, 4'h0);
  endtask

  task automatic test_out_of_range();
    xfer(0, 1'b0, 16'h0024, 32'h0, 4'h0);
    xfer(0, 1'b1, 16'h0024, 32'hFFFF_FFFF, 4'hF);
    xfer(0, 1'b1, 16'h0020, 32'h0BAD_0BAD, 4'hF);
    check_regq(0);
  endtask

  task automatic test_back_to_back();
    xfer(0, 1'b1, 16'h0000, 32'hA0A0_0001, 4'hF);
    xfer(0, 1'b1, 16'h0004, 32'hB1B1_0002, 4'hF);
    xfer(0, 1'b1, 16'h001C, 32'hC7C7_0007, 4'b1100);
    xfer(0, 1'b0, 16'h0000, 32'h0, 4'h0);
    xfer(0, 1'b0, 16'h0004, 32'h0, 4'h0);
    xfer(0, 1'b0, 16'h001C, 32'h0, 4'h0);
    check_regq(0);
  endtask

  task automatic test_wait_states();
    xfer(1, 1'b0, 16'h0004, 32'h0, 4'h0);
    xfer(1, 1'b1, 16'h0004, 32'h0000_1234, 4'hF);
    xfer(1, 1'b0, 16'h0004, 32'h0, 4'h0);
    xfer(1, 1'b0, 16'h0030, 32'h0, 4'h0);
    check_regq(1);
  endtask

  task automatic test_abort();
    bit seen;
    paddr = 16'h0004; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; pwstrb = 4'hF;
    psel_b = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel_b = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge pclk);
      if (pready_b !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_pready: got pready=1 after psel drop expected 0");
    end
    @(posedge pclk); #1;
    check_regq(1);
    xfer(1, 1'b0, 16'h0004, 32'h0, 4'h0);
  endtask

  task automatic test_reset_mid();
    paddr = 16'h0000; pwrite = 1'b1; pwdata = 32'hA5A5_A5A5; pwstrb = 4'hF;
    psel_b = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    model_reset();
    checks++;
    if (pready_b !== 1'b0 || prdata_b !== 32'h0 || pslverr_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_out: got pready=%b prdata=%h pslverr=%b expected 0/0/0",
               pready_b, prdata_b, pslverr_b);
    end
    check_regq(1);
    psel_b = 1'b0; penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(1, 1'b0, 16'h0000, 32'h0, 4'h0);
    check_regq(0);
    check_regq(1);
  endtask

  initial begin
    hw_b = '0;
    for (int i = 0; i < NR; i++) hw_a[32*i +: 32] = 32'hEE00_0000 | 32'(i);
    hw_a[95:64] = HW2;
    test_reset();
    test_read_all();
    test_strobes();
    test_read_only();
    test_out_of_range();
    test_back_to_back();
    test_wait_states();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_reg_bank.md
# apb_reg_bank

Parametrised APB4 slave register bank: successor to the fixed three-register APB slave. Provides `NUM_REGS` 32-bit registers with byte-strobe writes, per-register read-only mode fed from hardware, programmable wait states, and `pslverr` on illegal accesses. Sits directly on the APB bus as a leaf slave; register contents drive, and read-only registers sample, the surrounding logic.

## Interface
- `ADDR_W`, 16, `paddr` width; word index is `paddr[ADDR_W-1:2]`.
- `NUM_REGS`, 8, number of 32-bit registers, 1..256.
- `WAIT_STATES`, 0, extra access-phase cycles before `pready`, 0..15.
- `RO_MASK`, `'0`, `NUM_REGS` bits; bit i=1 makes register i read-only (value from `hw_rdata`).
- `RESET_VAL`, `32'h0`, reset value of every RW register.

Ports:
- `pclk`  in  1  the single clock.
- `presetn`  in  1  asynchronous, active-low reset.
- `paddr`  in  `ADDR_W`  byte address.
- `pprot`  in  3  protection; ignored.
- `psel`  in  1  slave select.
- `penable`  in  1  access phase.
- `pwrite`  in  1  1=write, 0=read.
- `pwdata`  in  32  write data.
- `pwstrb`  in  4  byte lane enables for writes.
- `pready`  out  1  transfer completion, registered.
- `prdata`  out  32  read data, valid when `pready`=1.
- `pslverr`  out  1  error response, valid when `pready`=1.
- `reg_q`  out  `NUM_REGS*32`  current register values; register i at `[32*i+:32]`.
- `hw_rdata`  in  `NUM_REGS*32`  hardware values for RO registers; unused bits for RW registers.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: on `psel & penable`, go to WAIT if `WAIT_STATES`>0 (load counter = `WAIT_STATES-1`), else DONE.
- WAIT: counter decrements each cycle; at 0 go to DONE. If `psel`=0, return to IDLE (aborted; no write, no response).
- DONE: `pready`=1 for exactly one cycle; always returns to IDLE next cycle.
- Error: index >= `NUM_REGS`, or write to an RO register. Errored writes modify nothing; errored reads return `prdata`=0.
- Write commits on the clock edge ending DONE: byte k of register updates iff `pwstrb[k]`=1; `pwstrb`=0 is a legal no-op.
- Read: `prdata` loaded on entry to DONE from register or `hw_rdata` (RO); `hw_rdata` sampled at that edge.
- `paddr[1:0]` ignored; no unaligned error.
- `prdata` and `pslverr` cleared to 0 when leaving DONE; they hold 0 outside DONE.

## Timing
- Reset (async assert, sync release by system): FSM=IDLE, `pready`=0, `prdata`=0, `pslverr`=0, all RW registers=`RESET_VAL`, counter=0.
- Access latency: `pready` high in the (`WAIT_STATES`+2)th cycle counting the first `penable` cycle as 1; `WAIT_STATES`=0 gives one wait cycle, as in the prior block.
- `reg_q` reflects a write the cycle after DONE.
- Back-to-back: a new setup phase may coincide with the DONE cycle; its access phase is accepted from IDLE next cycle.
- Reset mid-transfer: transfer dropped, no partial write, outputs at reset values immediately.

## Structure
- Package `apb_reg_pkg`: FSM state enum (`IDLE`, `WAIT`, `DONE`), `DATA_W`=32, `STRB_W`=4, wait-counter width constant (4).
- One natural sub-module: `apb_slave_fsm` (state, wait counter, `pready`, commit/abort strobes); register array and read mux stay in `apb_reg_bank`.

## Test plan
- Reset then read every index with `NUM_REGS`=8 -> `prdata`=`RESET_VAL`, `pslverr`=0, `pready` after 1 wait cycle.
- Write `32'hDEADBEEF` to index 3 with `pwstrb`=4'b0101 after writing `32'h0` -> read returns `32'h00AD00EF`, `reg_q[127:96]` matches.
- `RO_MASK`=8'h04, `hw_rdata` reg2=`32'h1234_5678`: read index 2 -> `32'h12345678`; write index 2 -> `pslverr`=1, value unchanged.
- Read/write index 9 -> `pslverr`=1, `prdata`=0, no register changes.
- `WAIT_STATES`=3: `pready` rises 5th access cycle; drop `psel` in cycle 2 of a write -> no write, FSM back to IDLE.
- Assert `presetn`=0 during WAIT of write `32'hA5A5A5A5` to index 0 -> `pready`=0 immediately, index 0 reads `RESET_VAL`.
